// File: rtl/pa_f_sram_arb_ctrl_pkg.sv
// Shared types and defaults for the SRAM sequencer/arbiter in front of pa_f_spsram_256x40.
package pa_f_sram_arb_ctrl_pkg;

    typedef enum logic {
        StInit = 1'b0,
        StRun  = 1'b1
    } ctrl_state_e;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataWidth = 40;
    localparam logic [63:0] DefInitWord  = 64'h0;

endpackage

// File: rtl/pa_f_sram_rr_arb.sv
// Two-way round-robin arbiter: combinational grant plus next pointer value.
module pa_f_sram_rr_arb (
    input  logic [1:0] vld,
    input  logic       ptr,
    output logic [1:0] gnt,
    output logic       ptr_nxt
);

    always_comb begin
        gnt = 2'b00;
        case (vld)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase

        // Pointer names the loser of the last granted cycle; idle cycles leave it alone.
        ptr_nxt = ptr;
        if (gnt[0]) begin
            ptr_nxt = 1'b1;
        end else if (gnt[1]) begin
            ptr_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/pa_f_sram_arb_ctrl.sv
// Init sweep sequencer and 2-requester round-robin front end for one single-port SRAM macro.
module pa_f_sram_arb_ctrl
    import pa_f_sram_arb_ctrl_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned            DATA_WIDTH = DefDataWidth,
    parameter bit                     INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0]  INIT_VAL   = DATA_WIDTH'(DefInitWord)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld_0,
    input  logic                  req_wr_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    input  logic [DATA_WIDTH-1:0] req_wmask_0,
    output logic                  req_rdy_0,
    output logic                  rsp_vld_0,
    output logic [DATA_WIDTH-1:0] rsp_data_0,
    input  logic                  req_vld_1,
    input  logic                  req_wr_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    input  logic [DATA_WIDTH-1:0] req_wmask_1,
    output logic                  req_rdy_1,
    output logic                  rsp_vld_1,
    output logic [DATA_WIDTH-1:0] rsp_data_1,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    ctrl_state_e           state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ptr_q;
    logic                  ptr_nxt;
    logic [1:0]            gnt;
    logic                  run_en;
    logic                  tag_rd_q;
    logic                  tag_id_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [DATA_WIDTH-1:0] sel_wmask;

    assign run_en = (state_q == StRun) && !RST;

    pa_f_sram_rr_arb u_arb (
        .vld     ({req_vld_1, req_vld_0} & {2{run_en}}),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign req_rdy_0 = gnt[0];
    assign req_rdy_1 = gnt[1];

    assign sel_wr    = gnt[1] ? req_wr_1    : req_wr_0;
    assign sel_addr  = gnt[1] ? req_addr_1  : req_addr_0;
    assign sel_wdata = gnt[1] ? req_wdata_1 : req_wdata_0;
    assign sel_wmask = gnt[1] ? req_wmask_1 : req_wmask_0;

    // Address/data hold their last driven value when idle so the macro output stays stable.
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = a_q;
        sram_d    = d_q;
        if (RST) begin
            sram_a = '0;
            sram_d = '0;
        end else if (state_q == StInit) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = cnt_q;
            sram_d    = INIT_VAL;
        end else if (|gnt) begin
            sram_cen = 1'b0;
            sram_a   = sel_addr;
            if (sel_wr) begin
                sram_gwen = ~(|sel_wmask);
                sram_wen  = ~sel_wmask;
                sram_d    = sel_wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= INIT_EN ? StInit : StRun;
            cnt_q     <= '0;
            init_done <= !INIT_EN;
            ptr_q     <= 1'b0;
            tag_rd_q  <= 1'b0;
            tag_id_q  <= 1'b0;
            a_q       <= '0;
            d_q       <= '0;
        end else begin
            a_q      <= sram_a;
            d_q      <= sram_d;
            ptr_q    <= ptr_nxt;
            tag_rd_q <= (|gnt) & ~sel_wr;
            tag_id_q <= gnt[1];
            case (state_q)
                StInit: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q   <= StRun;
                        init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Macro Q is already one cycle behind the grant, so it is steered straight to the tagged port.
    assign rsp_vld_0  = tag_rd_q & ~tag_id_q;
    assign rsp_vld_1  = tag_rd_q & tag_id_q;
    assign rsp_data_0 = rsp_vld_0 ? sram_q : '0;
    assign rsp_data_1 = rsp_vld_1 ? sram_q : '0;

endmodule

// File: tb/tb_pa_f_sram_arb_ctrl.sv
// Directed self-checking bench for pa_f_sram_arb_ctrl with a behavioural 256x40 SRAM per instance.
module tb_pa_f_sram_arb_ctrl;

    localparam int AW = 8;
    localparam int DW = 40;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance a: INIT_EN=1
    logic          a_RST;
    logic          a_req_vld_0, a_req_wr_0, a_req_rdy_0, a_rsp_vld_0;
    logic [AW-1:0] a_req_addr_0;
    logic [DW-1:0] a_req_wdata_0, a_req_wmask_0, a_rsp_data_0;
    logic          a_req_vld_1, a_req_wr_1, a_req_rdy_1, a_rsp_vld_1;
    logic [AW-1:0] a_req_addr_1;
    logic [DW-1:0] a_req_wdata_1, a_req_wmask_1, a_rsp_data_1;
    logic          a_init_done, a_sram_cen, a_sram_gwen;
    logic [AW-1:0] a_sram_a;
    logic [DW-1:0] a_sram_wen, a_sram_d, a_sram_q;
    logic [DW-1:0] mem_a [0:255];

    // Instance b: INIT_EN=0
    logic          b_RST;
    logic          b_req_vld_0, b_req_wr_0, b_req_rdy_0, b_rsp_vld_0;
    logic [AW-1:0] b_req_addr_0;
    logic [DW-1:0] b_req_wdata_0, b_req_wmask_0, b_rsp_data_0;
    logic          b_req_vld_1, b_req_wr_1, b_req_rdy_1, b_rsp_vld_1;
    logic [AW-1:0] b_req_addr_1;
    logic [DW-1:0] b_req_wdata_1, b_req_wmask_1, b_rsp_data_1;
    logic          b_init_done, b_sram_cen, b_sram_gwen;
    logic [AW-1:0] b_sram_a;
    logic [DW-1:0] b_sram_wen, b_sram_d, b_sram_q;
    logic [DW-1:0] mem_b [0:255];

    pa_f_sram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b1), .INIT_VAL('0)) u_dut_a (
        .CLK(CLK), .RST(a_RST),
        .req_vld_0(a_req_vld_0), .req_wr_0(a_req_wr_0), .req_addr_0(a_req_addr_0),
        .req_wdata_0(a_req_wdata_0), .req_wmask_0(a_req_wmask_0), .req_rdy_0(a_req_rdy_0),
        .rsp_vld_0(a_rsp_vld_0), .rsp_data_0(a_rsp_data_0),
        .req_vld_1(a_req_vld_1), .req_wr_1(a_req_wr_1), .req_addr_1(a_req_addr_1),
        .req_wdata_1(a_req_wdata_1), .req_wmask_1(a_req_wmask_1), .req_rdy_1(a_req_rdy_1),
        .rsp_vld_1(a_rsp_vld_1), .rsp_data_1(a_rsp_data_1),
        .init_done(a_init_done), .sram_a(a_sram_a), .sram_cen(a_sram_cen),
        .sram_gwen(a_sram_gwen), .sram_wen(a_sram_wen), .sram_d(a_sram_d), .sram_q(a_sram_q)
    );

    pa_f_sram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1'b0), .INIT_VAL('0)) u_dut_b (
        .CLK(CLK), .RST(b_RST),
        .req_vld_0(b_req_vld_0), .req_wr_0(b_req_wr_0), .req_addr_0(b_req_addr_0),
        .req_wdata_0(b_req_wdata_0), .req_wmask_0(b_req_wmask_0), .req_rdy_0(b_req_rdy_0),
        .rsp_vld_0(b_rsp_vld_0), .rsp_data_0(b_rsp_data_0),
        .req_vld_1(b_req_vld_1), .req_wr_1(b_req_wr_1), .req_addr_1(b_req_addr_1),
        .req_wdata_1(b_req_wdata_1), .req_wmask_1(b_req_wmask_1), .req_rdy_1(b_req_rdy_1),
        .rsp_vld_1(b_rsp_vld_1), .rsp_data_1(b_rsp_data_1),
        .init_done(b_init_done), .sram_a(b_sram_a), .sram_cen(b_sram_cen),
        .sram_gwen(b_sram_gwen), .sram_wen(b_sram_wen), .sram_d(b_sram_d), .sram_q(b_sram_q)
    );

    // Behavioural single-port macros: active-low CEN/GWEN/WEN, registered Q.
    always @(posedge CLK) begin
        if (!a_sram_cen) begin
            if (!a_sram_gwen)
                mem_a[a_sram_a] <= (mem_a[a_sram_a] & a_sram_wen) | (a_sram_d & ~a_sram_wen);
            else
                a_sram_q <= mem_a[a_sram_a];
        end
    end

    always @(posedge CLK) begin
        if (!b_sram_cen) begin
            if (!b_sram_gwen)
                mem_b[b_sram_a] <= (mem_b[b_sram_a] & b_sram_wen) | (b_sram_d & ~b_sram_wen);
            else
                b_sram_q <= mem_b[b_sram_a];
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_a();
        a_req_vld_0 = 1'b0; a_req_wr_0 = 1'b0; a_req_addr_0 = '0;
        a_req_wdata_0 = '0; a_req_wmask_0 = '0;
        a_req_vld_1 = 1'b0; a_req_wr_1 = 1'b0; a_req_addr_1 = '0;
        a_req_wdata_1 = '0; a_req_wmask_1 = '0;
    endtask

    task automatic test_reset();
        a_req_vld_0 = 1'b1;
        a_req_vld_1 = 1'b1;
        repeat (3) step();
        @(negedge CLK);
        n_checks++;
        if (a_init_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_init_done: got %b expected 0", a_init_done);
        end
        n_checks++;
        if (a_sram_cen !== 1'b1 || a_sram_gwen !== 1'b1) begin
            n_fail++; $display("FAIL reset_cen_gwen: got %b/%b expected 1/1", a_sram_cen, a_sram_gwen);
        end
        n_checks++;
        if (a_sram_wen !== {DW{1'b1}} || a_sram_a !== '0 || a_sram_d !== '0) begin
            n_fail++;
            $display("FAIL reset_sram_idle: wen %h a %h d %h expected all-ones/0/0",
                     a_sram_wen, a_sram_a, a_sram_d);
        end
        n_checks++;
        if (a_rsp_vld_0 !== 1'b0 || a_rsp_vld_1 !== 1'b0 || a_rsp_data_0 !== '0
            || a_rsp_data_1 !== '0) begin
            n_fail++;
            $display("FAIL reset_rsp: vld %b%b data %h %h expected 0", a_rsp_vld_1, a_rsp_vld_0,
                     a_rsp_data_1, a_rsp_data_0);
        end
        n_checks++;
        if (a_req_rdy_0 !== 1'b0 || a_req_rdy_1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_rdy: got %b%b expected 00", a_req_rdy_1, a_req_rdy_0);
        end
    endtask

    task automatic test_init_sweep();
        // a_req_vld_* stay high so any premature ready is visible.
        @(posedge CLK); #1;
        a_RST = 1'b0;
        for (int k = 0; k < 256; k++) begin
            @(negedge CLK);
            if (k == 0 || k == 100 || k == 255) begin
                n_checks++;
                if (a_sram_a !== AW'(k) || a_sram_cen !== 1'b0 || a_sram_gwen !== 1'b0
                    || a_sram_wen !== '0 || a_sram_d !== '0) begin
                    n_fail++;
                    $display("FAIL init_write cycle %0d: a %0d cen %b gwen %b wen %h d %h", k,
                             a_sram_a, a_sram_cen, a_sram_gwen, a_sram_wen, a_sram_d);
                end
            end
            n_checks++;
            if (a_req_rdy_0 !== 1'b0 || a_req_rdy_1 !== 1'b0 || a_init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL init_busy cycle %0d: rdy %b%b init_done %b expected 0", k,
                         a_req_rdy_1, a_req_rdy_0, a_init_done);
            end
            step();
        end
        @(negedge CLK);
        n_checks++;
        if (a_init_done !== 1'b1) begin
            n_fail++; $display("FAIL init_done_256: got %b expected 1", a_init_done);
        end
        n_checks++;
        if (a_req_rdy_0 !== 1'b1 || a_req_rdy_1 !== 1'b0) begin
            n_fail++; $display("FAIL init_first_rdy: got %b%b expected 01", a_req_rdy_1, a_req_rdy_0);
        end
        idle_a();
        step();
    endtask

    task automatic test_round_robin();
        logic e0, e1, r0, r1;
        a_req_vld_0 = 1'b1; a_req_addr_0 = 8'd1;
        a_req_vld_1 = 1'b1; a_req_addr_1 = 8'd2;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            e0 = (i % 2 == 0);
            e1 = (i % 2 == 1);
            r0 = (i > 0) && ((i - 1) % 2 == 0);
            r1 = (i > 0) && ((i - 1) % 2 == 1);
            n_checks++;
            if (a_req_rdy_0 !== e0 || a_req_rdy_1 !== e1) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d: got %b%b expected %b%b", i, a_req_rdy_1,
                         a_req_rdy_0, e1, e0);
            end
            n_checks++;
            if (a_sram_a !== (e0 ? 8'd1 : 8'd2) || a_sram_cen !== 1'b0 || a_sram_gwen !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_sram cycle %0d: a %0d cen %b gwen %b", i, a_sram_a, a_sram_cen,
                         a_sram_gwen);
            end
            n_checks++;
            if (a_rsp_vld_0 !== r0 || a_rsp_vld_1 !== r1) begin
                n_fail++;
                $display("FAIL rr_rsp cycle %0d: got %b%b expected %b%b", i, a_rsp_vld_1,
                         a_rsp_vld_0, r1, r0);
            end
            step();
        end
        idle_a();
        @(negedge CLK);
        n_checks++;
        if (a_rsp_vld_1 !== 1'b1 || a_rsp_vld_0 !== 1'b0 || a_rsp_data_1 !== '0) begin
            n_fail++;
            $display("FAIL rr_last_rsp: vld %b%b data %h expected 10 / 0", a_rsp_vld_1,
                     a_rsp_vld_0, a_rsp_data_1);
        end
        step();
    endtask

    task automatic test_init_reads();
        logic [AW-1:0] addrs [3];
        addrs[0] = 8'd0; addrs[1] = 8'd128; addrs[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            a_req_vld_0 = 1'b1; a_req_wr_0 = 1'b0; a_req_addr_0 = addrs[i];
            step();
            a_req_vld_0 = 1'b0;
            @(negedge CLK);
            n_checks++;
            if (a_rsp_vld_0 !== 1'b1 || a_rsp_data_0 !== '0 || a_rsp_vld_1 !== 1'b0) begin
                n_fail++;
                $display("FAIL init_read addr %0d: vld %b%b data %h expected 01 / 0", addrs[i],
                         a_rsp_vld_1, a_rsp_vld_0, a_rsp_data_0);
            end
            step();
        end
    endtask

    task automatic test_masked_write();
        a_req_vld_1 = 1'b1; a_req_wr_1 = 1'b1; a_req_addr_1 = 8'd5;
        a_req_wdata_1 = 40'hFF_FFFF_FFFF; a_req_wmask_1 = 40'h00_0000_00FF;
        @(negedge CLK);
        n_checks++;
        if (a_req_rdy_1 !== 1'b1 || a_sram_gwen !== 1'b0 || a_sram_wen !== 40'hFF_FFFF_FF00
            || a_sram_d !== 40'hFF_FFFF_FFFF || a_sram_a !== 8'd5) begin
            n_fail++;
            $display("FAIL mwr_sram: rdy %b gwen %b wen %h d %h a %0d", a_req_rdy_1, a_sram_gwen,
                     a_sram_wen, a_sram_d, a_sram_a);
        end
        step();
        a_req_wr_1 = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (a_rsp_vld_1 !== 1'b0) begin
            n_fail++; $display("FAIL mwr_no_rsp: got %b expected 0", a_rsp_vld_1);
        end
        step();
        a_req_vld_1 = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (a_rsp_vld_1 !== 1'b1 || a_rsp_data_1 !== 40'h00_0000_00FF) begin
            n_fail++;
            $display("FAIL mwr_readback: vld %b data %h expected 1 / 00000000ff", a_rsp_vld_1,
                     a_rsp_data_1);
        end
        idle_a();
        step();
    endtask

    task automatic test_read_after_write();
        a_req_vld_0 = 1'b1; a_req_wr_0 = 1'b1; a_req_addr_0 = 8'd7;
        a_req_wdata_0 = 40'h12_3456_789A; a_req_wmask_0 = '1;
        step();
        a_req_wr_0 = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (a_rsp_vld_0 !== 1'b0 || a_sram_gwen !== 1'b1 || a_sram_cen !== 1'b0) begin
            n_fail++;
            $display("FAIL raw_read_issue: rsp %b gwen %b cen %b expected 0/1/0", a_rsp_vld_0,
                     a_sram_gwen, a_sram_cen);
        end
        step();
        a_req_vld_0 = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (a_rsp_vld_0 !== 1'b1 || a_rsp_data_0 !== 40'h12_3456_789A) begin
            n_fail++;
            $display("FAIL raw_data: vld %b data %h expected 1 / 123456789a", a_rsp_vld_0,
                     a_rsp_data_0);
        end
        step();
        @(negedge CLK);
        n_checks++;
        if (a_rsp_vld_0 !== 1'b0) begin
            n_fail++; $display("FAIL raw_pulse: got %b expected 0", a_rsp_vld_0);
        end
        n_checks++;
        if (a_sram_cen !== 1'b1 || a_sram_wen !== {DW{1'b1}} || a_sram_a !== 8'd7
            || a_sram_d !== 40'h12_3456_789A) begin
            n_fail++;
            $display("FAIL idle_hold: cen %b wen %h a %0d d %h expected 1/ones/7/123456789a",
                     a_sram_cen, a_sram_wen, a_sram_a, a_sram_d);
        end
        idle_a();
    endtask

    task automatic test_reset_mid_init();
        a_RST = 1'b1;
        step();
        a_RST = 1'b0;
        for (int k = 0; k < 100; k++) step();
        @(negedge CLK);
        n_checks++;
        if (a_sram_a !== 8'd100 || a_init_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_counter: a %0d init_done %b expected 100 / 0", a_sram_a, a_init_done);
        end
        a_RST = 1'b1;
        step();
        a_RST = 1'b0;
        for (int k = 0; k < 256; k++) begin
            @(negedge CLK);
            if (k == 0 || k == 255) begin
                n_checks++;
                if (a_sram_a !== AW'(k) || a_init_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_restart cycle %0d: a %0d init_done %b", k, a_sram_a,
                             a_init_done);
                end
            end
            step();
        end
        @(negedge CLK);
        n_checks++;
        if (a_init_done !== 1'b1) begin
            n_fail++; $display("FAIL mid_done: got %b expected 1", a_init_done);
        end
    endtask

    task automatic test_init_en0();
        b_req_vld_0 = 1'b1; b_req_wr_0 = 1'b1; b_req_addr_0 = 8'd9;
        b_req_wdata_0 = 40'hAA_AAAA_AAAA; b_req_wmask_0 = '0;
        @(negedge CLK);
        n_checks++;
        if (b_req_rdy_0 !== 1'b0 || b_sram_cen !== 1'b1) begin
            n_fail++;
            $display("FAIL en0_in_reset: rdy %b cen %b expected 0/1", b_req_rdy_0, b_sram_cen);
        end
        @(posedge CLK); #1;
        b_RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (b_init_done !== 1'b1 || b_req_rdy_0 !== 1'b1) begin
            n_fail++;
            $display("FAIL en0_first_cycle: init_done %b rdy %b expected 1/1", b_init_done,
                     b_req_rdy_0);
        end
        n_checks++;
        if (b_sram_gwen !== 1'b1 || b_sram_cen !== 1'b0 || b_sram_wen !== {DW{1'b1}}) begin
            n_fail++;
            $display("FAIL en0_zero_mask: gwen %b cen %b wen %h expected 1/0/ones", b_sram_gwen,
                     b_sram_cen, b_sram_wen);
        end
        step();
        b_req_vld_0 = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (b_rsp_vld_0 !== 1'b0 || b_rsp_vld_1 !== 1'b0) begin
            n_fail++; $display("FAIL en0_no_rsp: got %b%b expected 00", b_rsp_vld_1, b_rsp_vld_0);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_b[i] = '0;
        a_RST = 1'b1;
        b_RST = 1'b1;
        idle_a();
        b_req_vld_0 = 1'b0; b_req_wr_0 = 1'b0; b_req_addr_0 = '0;
        b_req_wdata_0 = '0; b_req_wmask_0 = '0;
        b_req_vld_1 = 1'b0; b_req_wr_1 = 1'b0; b_req_addr_1 = '0;
        b_req_wdata_1 = '0; b_req_wmask_1 = '0;

        test_reset();
        test_init_sweep();
        test_round_robin();
        test_init_reads();
        test_masked_write();
        test_read_after_write();
        test_reset_mid_init();
        test_init_en0();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
